// File: rtl/core_perf_monitor_pkg.sv
// Shared definitions for the core performance monitor: run/done state encodings
// and the fixed display-select codes.
package core_perf_monitor_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Select 0 shows the total; cores follow at 1..N, then the live counter.
  localparam int unsigned SEL_END_CNT     = 0;
  localparam int unsigned SEL_LIVE_OFFSET = 1;

endpackage

// File: rtl/perf_capture_slot.sv
// One per core: sticky completion flag plus the cycle count captured when the
// core first reported halt.
module perf_capture_slot #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else if (capture_i) begin
      done_q <= 1'b1;
      cnt_q  <= value_i;
    end
  end

  assign done_o = done_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/core_perf_monitor.sv
// Counts cycles from reset release until every core has halted, records each
// core's halt cycle, and drives a registered display word for the board.
module core_perf_monitor
  import core_perf_monitor_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CNT_W      = 32,
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    halt,
  input  logic [SEL_W-1:0]        disp_sel,
  output logic [NUM_CORES-1:0]    core_done,
  output logic                    all_done,
  output logic                    done_pulse,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] disp_value
);

  localparam int DISP_W = 4 * NUM_DIGITS;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  end_q, end_d;
  logic              overflow_q, overflow_d;
  logic              pulse_q, pulse_d;
  logic [DISP_W-1:0] disp_q, disp_d;

  logic [NUM_CORES-1:0] capture;
  logic [NUM_CORES-1:0] halt_eff;
  logic [CNT_W-1:0]     core_cnt [NUM_CORES];
  logic                 running;
  logic                 all_halted;
  logic [CNT_W-1:0]     sel_val;
  logic                 sel_fill;

  // A core stays complete once captured, even if its halt line later drops.
  assign running    = (state_q == ST_RUN);
  assign halt_eff   = halt | core_done;
  assign all_halted = &halt_eff;
  assign capture    = running ? (halt & ~core_done) : '0;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    perf_capture_slot #(
      .CNT_W(CNT_W)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .capture_i(capture[g]),
      .value_i  (cyc_q),
      .done_o   (core_done[g]),
      .cnt_o    (core_cnt[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    end_d      = end_q;
    overflow_d = overflow_q;
    pulse_d    = 1'b0;
    if (running) begin
      if (all_halted) begin
        end_d   = cyc_q;
        state_d = ST_DONE;
        pulse_d = 1'b1;
      end else if (cyc_q != '1) begin
        cyc_d = cyc_q + CNT_W'(1);
        if (cyc_d == '1) overflow_d = 1'b1;
      end
    end
  end

  // Display source mux; unsupported codes show an all-ones pattern.
  always_comb begin
    sel_val  = '0;
    sel_fill = 1'b0;
    if (disp_sel == SEL_W'(SEL_END_CNT)) begin
      sel_val = end_q;
    end else if (disp_sel == SEL_W'(NUM_CORES + SEL_LIVE_OFFSET)) begin
      sel_val = cyc_q;
    end else begin
      sel_fill = 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (disp_sel == SEL_W'(i + 1)) begin
          sel_val  = core_cnt[i];
          sel_fill = 1'b0;
        end
      end
    end
    disp_d = sel_fill ? '1 : DISP_W'(sel_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cyc_q      <= '0;
      end_q      <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      end_q      <= end_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
      disp_q     <= disp_d;
    end
  end

  assign all_done   = (state_q == ST_DONE);
  assign done_pulse = pulse_q;
  assign overflow   = overflow_q;
  assign disp_value = disp_q;

endmodule

// File: tb/tb_core_perf_monitor.sv
// Bench for core_perf_monitor: a wide (32-bit) and a narrow (8-bit) instance
// share stimulus and are checked against a cycle-index reference model.
module tb_core_perf_monitor;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] halt;
  logic [3:0]    disp_sel;

  logic [NC-1:0] a_core_done, b_core_done;
  logic          a_all_done, a_done_pulse, a_overflow;
  logic          b_all_done, b_done_pulse, b_overflow;
  logic [15:0]   a_disp;
  logic [7:0]    b_disp;

  always #5 clk = ~clk;

  core_perf_monitor #(.NUM_CORES(NC), .CNT_W(32), .NUM_DIGITS(4), .SEL_W(4)) u_a (
    .clk(clk), .reset(reset), .halt(halt), .disp_sel(disp_sel),
    .core_done(a_core_done), .all_done(a_all_done), .done_pulse(a_done_pulse),
    .overflow(a_overflow), .disp_value(a_disp)
  );

  core_perf_monitor #(.NUM_CORES(NC), .CNT_W(8), .NUM_DIGITS(2), .SEL_W(4)) u_b (
    .clk(clk), .reset(reset), .halt(halt), .disp_sel(disp_sel),
    .core_done(b_core_done), .all_done(b_all_done), .done_pulse(b_done_pulse),
    .overflow(b_overflow), .disp_value(b_disp)
  );

  // Reference model: unbounded cycle index, saturated per instance width on compare.
  bit          m_run;
  longint      m_cyc, m_end;
  longint      m_core [NC];
  bit [NC-1:0] m_done;
  bit          m_pulse, m_fill;
  longint      m_raw;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint max_of(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sat(input longint v, input int w);
    return (v > max_of(w)) ? max_of(w) : v;
  endfunction

  function automatic longint exp_disp(input int w, input int dw);
    return m_fill ? max_of(dw) : (sat(m_raw, w) & max_of(dw));
  endfunction

  task automatic step();
    bit          n_run;
    longint      n_cyc, n_end, n_raw;
    longint      n_core [NC];
    bit [NC-1:0] n_done;
    bit          n_pulse, n_fill;
    n_run = m_run; n_cyc = m_cyc; n_end = m_end; n_done = m_done;
    for (int i = 0; i < NC; i++) n_core[i] = m_core[i];
    n_pulse = 1'b0;
    n_fill  = 1'b0;
    n_raw   = 0;
    if (disp_sel == 0)            n_raw = m_end;
    else if (disp_sel <= NC)      n_raw = m_core[disp_sel - 1];
    else if (disp_sel == NC + 1)  n_raw = m_cyc;
    else                          n_fill = 1'b1;
    if (reset) begin
      n_run = 1'b1; n_cyc = 0; n_end = 0; n_done = '0;
      for (int i = 0; i < NC; i++) n_core[i] = 0;
      n_fill = 1'b0; n_raw = 0;
    end else if (m_run) begin
      for (int i = 0; i < NC; i++)
        if (halt[i] && !m_done[i]) begin
          n_core[i] = m_cyc;
          n_done[i] = 1'b1;
        end
      if ($countones(halt | m_done) == NC) begin
        n_end = m_cyc; n_run = 1'b0; n_pulse = 1'b1;
      end else begin
        n_cyc = m_cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    m_run = n_run; m_cyc = n_cyc; m_end = n_end; m_done = n_done;
    for (int i = 0; i < NC; i++) m_core[i] = n_core[i];
    m_pulse = n_pulse; m_fill = n_fill; m_raw = n_raw;

    check_eq("a.core_done", a_core_done, m_done);
    check_eq("a.all_done", a_all_done, !m_run);
    check_eq("a.done_pulse", a_done_pulse, m_pulse);
    check_eq("a.overflow", a_overflow, m_cyc >= max_of(32));
    check_eq("a.disp", a_disp, exp_disp(32, 16));
    check_eq("b.core_done", b_core_done, m_done);
    check_eq("b.all_done", b_all_done, !m_run);
    check_eq("b.done_pulse", b_done_pulse, m_pulse);
    check_eq("b.overflow", b_overflow, m_cyc >= max_of(8));
    check_eq("b.disp", b_disp, exp_disp(8, 8));
  endtask

  // Drive halts from per-core target cycles until completion or the cycle limit.
  task automatic run_sched(input int t [NC], input int drop_core, input int drop_at,
                           input int limit, input bit sweep, input bit noise);
    for (int c = 0; c < limit && m_run; c++) begin
      reset = 1'b0;
      for (int i = 0; i < NC; i++) begin
        halt[i] = (m_cyc >= t[i]) && !(i == drop_core && m_cyc >= drop_at);
        if (noise && m_cyc > t[i]) halt[i] = ($urandom_range(0, 1) == 1);
      end
      disp_sel = sweep ? 4'(c % 8) : 4'($urandom_range(0, 7));
      step();
    end
  endtask

  task automatic tail_and_reset();
    for (int c = 0; c < 3; c++) begin
      halt = NC'($urandom);
      disp_sel = 4'($urandom_range(0, 7));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic show(input int sel);
    halt = NC'($urandom);
    disp_sel = 4'(sel);
    step();
  endtask

  int t [NC];
  int exp2 [5];

  initial begin
    reset = 1'b1; halt = '1; disp_sel = '0;
    m_run = 1'b1; m_cyc = 0; m_end = 0; m_done = '0;
    m_pulse = 1'b0; m_fill = 1'b0; m_raw = 0;
    for (int i = 0; i < NC; i++) m_core[i] = 0;

    // Reset held with all halts high, then every core halts in cycle 0.
    for (int c = 0; c < 3; c++) step();
    check_eq("s1.reset_disp", a_disp, 0);
    reset = 1'b0;
    step();
    check_eq("s1.pulse", a_done_pulse, 1);
    check_eq("s1.core_done", a_core_done, 4'hF);
    show(0);
    check_eq("s1.end_disp", a_disp, 0);
    tail_and_reset();

    // Staggered halts; the latest core sets the total.
    t = '{31, 22, 23, 24};
    run_sched(t, -1, 0, 200, 1'b0, 1'b0);
    exp2 = '{31, 31, 22, 23, 24};
    for (int s = 0; s < 5; s++) begin
      show(s);
      check_eq($sformatf("s2.sel%0d", s), a_disp, 64'(exp2[s]));
    end
    tail_and_reset();

    // Core 2 halts at 10 and drops at 12; completion stays sticky.
    t = '{20, 10, 25, 18};
    run_sched(t, 1, 12, 200, 1'b0, 1'b0);
    show(2);
    check_eq("s3.core2", a_disp, 10);
    show(0);
    check_eq("s3.end", a_disp, 25);
    tail_and_reset();

    // Long run: the narrow instance saturates at 255.
    t = '{300, 300, 300, 300};
    run_sched(t, -1, 0, 400, 1'b0, 1'b0);
    check_eq("s4.b_overflow", b_overflow, 1);
    show(0);
    check_eq("s4.b_end", b_disp, 8'hFF);
    check_eq("s4.a_end", a_disp, 16'h012C);
    tail_and_reset();

    // Select sweep while counting.
    t = '{1000, 1000, 1000, 1000};
    run_sched(t, -1, 0, 40, 1'b1, 1'b0);
    show(6);
    check_eq("s5.sel6", a_disp, 16'hFFFF);
    tail_and_reset();

    // Reset mid-run at cycle 15, then a full run ending in a reset from DONE.
    t = '{100, 3, 100, 7};
    run_sched(t, -1, 0, 15, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("s6.cleared", a_core_done, 0);
    t = '{5, 9, 2, 14};
    run_sched(t, -1, 0, 100, 1'b0, 1'b0);
    tail_and_reset();

    // Randomised schedules with halt noise after each core's first halt.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NC; i++) t[i] = $urandom_range(0, 60);
      run_sched(t, $urandom_range(0, NC), $urandom_range(0, 60), 200, 1'b0, 1'b1);
      tail_and_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
